mul_sched: RTL and testbench

Round-robin scheduler that shares one U(TOTAL_BITS−FRACTIONAL_BITS, FRACTIONAL_BITS) fixed-point multiplier between REQUESTERS independent clients, such as voice gain and envelope stages. It accepts at most one operand pair per cycle over per-requester valid/ready handshakes and pipelines the product through two register stages. It returns each result tagged with the originating requester's index. It sits between the per-voice datapaths and the single multiplier resource.

---
 rtl/synth_pkg.sv | 18 +
 rtl/mul_sched_if.sv | 32 +++
 rtl/mul.sv | 25 ++
 rtl/mul_sched.sv | 113 +++++++++++
 tb/tb_mul_sched.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared fixed-point definitions for the synth datapath blocks.
// Holds the default operand widths, the default unsigned fixed-point type
// and the requester-ID width helper. No ports.
package synth_pkg;

    localparam int FIX_TOTAL_BITS = 16;
    localparam int FIX_FRAC_BITS  = 8;

    // Unsigned U(FIX_TOTAL_BITS-FIX_FRAC_BITS, FIX_FRAC_BITS) value.
    typedef logic [FIX_TOTAL_BITS-1:0] fix_t;

    // Width of a requester index. Never returns zero, so a
    // single-client build still gets a legal one-bit vector.
    function automatic int id_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_sched_if.sv
// Request/response bundle between the per-voice clients and mul_sched.
// master: client side (drives req_valid/req_a/req_b, sees grant and results).
// slave:  scheduler side (drives req_ready, resp_valid/resp_id/resp_data, busy).
interface mul_sched_if
    import synth_pkg::*;
#(
    parameter int TOTAL_BITS      = FIX_TOTAL_BITS,
    parameter int FRACTIONAL_BITS = FIX_FRAC_BITS,
    parameter int REQUESTERS      = 4
);
    localparam int ID_BITS = id_bits(REQUESTERS);

    logic [REQUESTERS-1:0]                 req_valid;
    logic [REQUESTERS-1:0]                 req_ready;
    logic [REQUESTERS-1:0][TOTAL_BITS-1:0] req_a;
    logic [REQUESTERS-1:0][TOTAL_BITS-1:0] req_b;
    logic                                  resp_valid;
    logic [ID_BITS-1:0]                    resp_id;
    logic [TOTAL_BITS-1:0]                 resp_data;
    logic                                  busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_id, resp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_id, resp_data, busy
    );

endinterface

// File: rtl/mul.sv
// Combinational unsigned fixed-point multiplier, zero latency, no handshake.
// Ports: a_i, b_i operands; p_o product in the operand format, fractional
// LSBs truncated and integer overflow wrapped.
module mul
    import synth_pkg::*;
#(
    parameter int TOTAL_BITS      = FIX_TOTAL_BITS,
    parameter int FRACTIONAL_BITS = FIX_FRAC_BITS
) (
    input  logic [TOTAL_BITS-1:0] a_i,
    input  logic [TOTAL_BITS-1:0] b_i,
    output logic [TOTAL_BITS-1:0] p_o
);

    logic [2*TOTAL_BITS-1:0] prod;
    logic                    unused_bits;

    assign prod = (2*TOTAL_BITS)'(a_i) * (2*TOTAL_BITS)'(b_i);
    assign p_o  = prod[TOTAL_BITS+FRACTIONAL_BITS-1 -: TOTAL_BITS];

    // Discarded fraction LSBs and overflowed integer MSBs.
    assign unused_bits = ^{prod[2*TOTAL_BITS-1:TOTAL_BITS+FRACTIONAL_BITS],
                           prod[FRACTIONAL_BITS-1:0]};

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one fixed-point multiplier among REQUESTERS clients.
// Latency: grant at edge t -> resp_valid during cycle t+2; one issue per cycle overall.
// Backpressure: none downstream; req_ready is a combinational one-hot grant, zero in reset.
// Ports: clk, reset (sync, active-high), bus (mul_sched_if.slave).
module mul_sched
    import synth_pkg::*;
#(
    parameter int TOTAL_BITS      = FIX_TOTAL_BITS,
    parameter int FRACTIONAL_BITS = FIX_FRAC_BITS,
    parameter int REQUESTERS      = 4
) (
    input  logic        clk,
    input  logic        reset,
    mul_sched_if.slave  bus
);

    localparam int ID_BITS = id_bits(REQUESTERS);

    logic [ID_BITS-1:0]    ptr_q, ptr_d;
    logic [REQUESTERS-1:0] grant;
    logic [ID_BITS-1:0]    gnt_id;
    logic                  fire;

    logic                  s1_valid_q;
    logic [ID_BITS-1:0]    s1_id_q;
    logic [TOTAL_BITS-1:0] s1_a_q, s1_b_q;

    logic                  s2_valid_q;
    logic [ID_BITS-1:0]    s2_id_q;
    logic [TOTAL_BITS-1:0] s2_data_q;

    logic [TOTAL_BITS-1:0] mul_p;

    // First valid requester at or after ptr, wrapping around.
    function automatic logic [REQUESTERS-1:0] rr_pick(
        input logic [REQUESTERS-1:0] vld,
        input logic [ID_BITS-1:0]    ptr
    );
        logic [REQUESTERS-1:0] g;
        logic                  found;
        int                    idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = (int'(ptr) + k) % REQUESTERS;
            if (!found && vld[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        if (!reset) begin
            grant = rr_pick(bus.req_valid, ptr_q);
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant[i]) begin
                gnt_id = ID_BITS'(i);
            end
        end
        fire  = |grant;
        ptr_d = ptr_q;
        if (fire) begin
            // Explicit wrap keeps non-power-of-two requester counts correct.
            ptr_d = (gnt_id == ID_BITS'(REQUESTERS-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    assign bus.req_ready = grant;

    mul #(
        .TOTAL_BITS      (TOTAL_BITS),
        .FRACTIONAL_BITS (FRACTIONAL_BITS)
    ) u_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (mul_p)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= fire;
            if (fire) begin
                s1_id_q <= gnt_id;
                s1_a_q  <= bus.req_a[gnt_id];
                s1_b_q  <= bus.req_b[gnt_id];
            end
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_data_q  <= mul_p;
        end
    end

    assign bus.resp_valid = s2_valid_q;
    assign bus.resp_id    = s2_id_q;
    assign bus.resp_data  = s2_data_q;
    assign bus.busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched: directed issues push the hand-computed
// {id, data, arrival cycle} into a queue; a monitor pops and compares each
// resp_valid pulse, and flags any result that was not expected.
module tb_mul_sched;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    mul_sched_if #(.TOTAL_BITS(16), .FRACTIONAL_BITS(8), .REQUESTERS(4)) bus ();

    mul_sched #(.TOTAL_BITS(16), .FRACTIONAL_BITS(8), .REQUESTERS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] oh2id(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Drive valids for one cycle, check the grant, and queue the expected result.
    task automatic issue(input logic [3:0] vld, input logic [3:0] exp_rdy,
                         input logic [15:0] exp_data, input bit want_resp, input string nm);
        exp_t e;
        @(negedge clk);
        bus.req_valid = vld;
        #1;
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
        if (want_resp && exp_rdy != 4'd0) begin
            e.id   = oh2id(exp_rdy);
            e.data = exp_data;
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i] = a;
        bus.req_b[i] = b;
    endtask

    // Monitor: every result must match the oldest outstanding expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got id=%0d data=%0h expected no result (cycle %0d)",
                         bus.resp_id, bus.resp_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_id",   32'(bus.resp_id),   32'(e.id));
                chk("resp_data", 32'(bus.resp_data), 32'(e.data));
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        bus.req_valid = 4'd0;
        for (int i = 0; i < 4; i++) set_ops(i, 16'd0, 16'd0);

        // Reset: requests presented during reset are never granted.
        repeat (2) @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 4'd0;
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_id",    32'(bus.resp_id),    32'd0);
        chk("rst_resp_data",  32'(bus.resp_data),  32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);

        // Single multiply 1.5 * 2.0 = 3.0
        set_ops(0, 16'h0180, 16'h0200);
        issue(4'b0001, 4'b0001, 16'h0300, 1'b1, "single");
        chk("busy_s1", 32'(bus.busy), 32'd1);
        issue(4'b0000, 4'b0000, 16'h0000, 1'b0, "idle0");
        chk("busy_s2", 32'(bus.busy), 32'd1);
        issue(4'b0000, 4'b0000, 16'h0000, 1'b0, "idle1");
        chk("busy_drained", 32'(bus.busy), 32'd0);

        // Wrap, truncation, identity (ptr now 1)
        set_ops(1, 16'h1000, 16'h1000);
        set_ops(2, 16'h0001, 16'h0080);
        set_ops(3, 16'h0100, 16'h0123);
        issue(4'b0010, 4'b0010, 16'h0000, 1'b1, "wrap");
        issue(4'b0100, 4'b0100, 16'h0000, 1'b1, "trunc");
        issue(4'b1000, 4'b1000, 16'h0123, 1'b1, "ident");

        // Fairness: all valid, ptr back at 0
        for (int i = 0; i < 4; i++) set_ops(i, 16'((i + 1) * 256), 16'h0200);
        for (int r = 0; r < 2; r++) begin
            issue(4'hF, 4'b0001, 16'h0200, 1'b1, "fair");
            issue(4'hF, 4'b0010, 16'h0400, 1'b1, "fair");
            issue(4'hF, 4'b0100, 16'h0600, 1'b1, "fair");
            issue(4'hF, 4'b1000, 16'h0800, 1'b1, "fair");
        end

        // Pointer resume: grant 2, then only 1 and 3 valid -> 3 before 1
        issue(4'b0100, 4'b0100, 16'h0600, 1'b1, "resume_g2");
        issue(4'b1010, 4'b1000, 16'h0800, 1'b1, "resume_g3");
        issue(4'b1010, 4'b0010, 16'h0400, 1'b1, "resume_g1");

        // Withdrawn: 2 waits behind 0, then drops valid
        issue(4'b1000, 4'b1000, 16'h0800, 1'b1, "wd_g3");
        issue(4'b0101, 4'b0001, 16'h0200, 1'b1, "wd_g0");
        issue(4'b0000, 4'b0000, 16'h0000, 1'b0, "wd_drop");
        issue(4'b0000, 4'b0000, 16'h0000, 1'b0, "wd_idle");
        issue(4'b0000, 4'b0000, 16'h0000, 1'b0, "wd_idle");

        // Mid-flight reset: issue to 1 (ptr 1), reset on the following edge
        issue(4'b0010, 4'b0010, 16'h0000, 1'b0, "mf_g1");
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        chk("mf_ready_in_reset", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 4'd0;
        #1;
        chk("mf_busy", 32'(bus.busy), 32'd0);
        chk("mf_resp_valid", 32'(bus.resp_valid), 32'd0);
        issue(4'hF, 4'b0001, 16'h0200, 1'b1, "mf_after");
        repeat (4) issue(4'b0000, 4'b0000, 16'h0000, 1'b0, "drain");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
